xgmii_rx_fcs_checker: RTL

- Receive-side frame checker on the 64-bit XGMII path, fed directly from the XGMII RX interface.
- Delimits frames by Start/Terminate control characters and strips the preamble/SFD word.
- Drives the existing combinational crc32_calc stage one beat at a time, holding the running CRC in a register.
- At frame end, reports FCS validity, byte length and error flags, and keeps good/bad frame counters.

---
 rtl/xgmii_pkg.sv | 30 +++
 rtl/xgmii_rx_fcs_checker_crc32_calc.sv | 28 ++
 rtl/xgmii_rx_fcs_checker.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/xgmii_pkg.sv
// Shared constants and types for the XGMII receive path.
package xgmii_pkg;

    // XGMII control characters
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_ERR   = 8'hFE;

    // Lanes 1..7 of a start beat: six preamble bytes then the SFD in lane 7
    localparam logic [55:0] PREAMBLE_SFD = 56'hD5_55_55_55_55_55_55;

    // Reflected CRC-32, seed and the raw register value expected after the FCS
    localparam logic [31:0] CRC_POLY        = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE_RAW = 32'h2144DF1C;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } fsm_state_e;

    typedef struct packed {
        logic        crc_ok;
        logic        len_err;
        logic        ctrl_err;
        logic [15:0] len;
    } frame_status_t;

endpackage

// File: rtl/xgmii_rx_fcs_checker_crc32_calc.sv
// Combinational CRC-32 update over the lowest nbytes lanes of a 64-bit beat.
// Lane 0 is folded in first, each byte LSB first.
module crc32_calc
    import xgmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [63:0] data,
    input  logic [3:0]  nbytes,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // Bit-serial reflected CRC unrolled across up to eight bytes
    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                c = c ^ {24'd0, data[8*i +: 8]};
                for (int j = 0; j < 8; j++) begin
                    c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
                end
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/xgmii_rx_fcs_checker.sv
// XGMII RX frame checker: delimits frames, runs CRC-32 over DA..FCS,
// reports FCS/length/control status per frame and counts good/bad frames.
// status_valid is a single-cycle pulse with no backpressure; the status
// fields and counters are stable from that pulse until the next one.
module xgmii_rx_fcs_checker
    import xgmii_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      xgmii_rxd,
    input  logic [7:0]       xgmii_rxc,
    output logic             status_valid,
    output logic             status_crc_ok,
    output logic             status_len_err,
    output logic             status_ctrl_err,
    output logic [15:0]      status_len,
    output logic [CNT_W-1:0] good_frames,
    output logic [CNT_W-1:0] bad_frames
);

    // Index of the lowest control lane; only meaningful when rxc != 0
    function automatic logic [2:0] first_ctrl(input logic [7:0] rxc);
        logic [2:0] idx;
        idx = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (rxc[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic len_bad(input logic [15:0] l);
        return (l < 16'(MIN_LEN)) || (l > 16'(MAX_LEN));
    endfunction

    logic [63:0]   rxd_q;
    logic [7:0]    rxc_q;
    fsm_state_e    state, state_nxt;
    logic [31:0]   crc_q, crc_nxt, crc_calc_out;
    logic [15:0]   len_q, len_nxt, len_add;
    logic [16:0]   len_sum;
    logic          frame_err_q, frame_err_nxt;
    logic          pend_valid_q, pend_valid_nxt;
    frame_status_t pend_q, pend_nxt;
    logic          is_start, pre_ok;
    logic [2:0]    term_lane;
    logic [7:0]    term_char;
    logic [3:0]    crc_nbytes;

    // Stage 1: capture the raw XGMII beat every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_q <= '0;
            rxc_q <= '0;
        end else begin
            rxd_q <= xgmii_rxd;
            rxc_q <= xgmii_rxc;
        end
    end

    assign is_start   = (rxc_q == 8'h01) && (rxd_q[7:0] == XGMII_START);
    assign pre_ok     = (rxd_q[63:8] == PREAMBLE_SFD);
    assign term_lane  = first_ctrl(rxc_q);
    assign term_char  = rxd_q[{term_lane, 3'b000} +: 8];
    assign crc_nbytes = (rxc_q == 8'h00) ? 4'd8 : {1'b0, term_lane};
    assign len_sum    = {1'b0, len_q} + {13'd0, crc_nbytes};
    assign len_add    = len_sum[16] ? 16'hFFFF : len_sum[15:0];

    crc32_calc u_crc (
        .crc_in  (crc_q),
        .data    (rxd_q),
        .nbytes  (crc_nbytes),
        .crc_out (crc_calc_out)
    );

    // Stage 2 decode: frame delimiting, CRC/length accumulation, report capture
    always_comb begin
        state_nxt      = state;
        crc_nxt        = crc_q;
        len_nxt        = len_q;
        frame_err_nxt  = frame_err_q;
        pend_valid_nxt = 1'b0;
        pend_nxt       = '0;
        case (state)
            IDLE: begin
                if (is_start) begin
                    state_nxt     = DATA;
                    crc_nxt       = CRC_INIT;
                    len_nxt       = '0;
                    frame_err_nxt = !pre_ok;
                end
            end
            DATA: begin
                if (rxc_q == 8'h00) begin
                    crc_nxt = crc_calc_out;
                    len_nxt = len_add;
                end else if (term_char == XGMII_TERM) begin
                    crc_nxt           = crc_calc_out;
                    len_nxt           = len_add;
                    pend_valid_nxt    = 1'b1;
                    pend_nxt.crc_ok   = (crc_calc_out == CRC_RESIDUE_RAW);
                    pend_nxt.len_err  = len_bad(len_add);
                    pend_nxt.ctrl_err = frame_err_q;
                    pend_nxt.len      = len_add;
                    state_nxt         = IDLE;
                end else begin
                    // Unexpected control: close the frame using only the bytes seen so far
                    pend_valid_nxt    = 1'b1;
                    pend_nxt.crc_ok   = 1'b0;
                    pend_nxt.len_err  = len_bad(len_q);
                    pend_nxt.ctrl_err = 1'b1;
                    pend_nxt.len      = len_q;
                    if (is_start) begin
                        crc_nxt       = CRC_INIT;
                        len_nxt       = '0;
                        frame_err_nxt = !pre_ok;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 2 state: FSM, running CRC, length and the pending report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            crc_q        <= CRC_INIT;
            len_q        <= '0;
            frame_err_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
        end else begin
            state        <= state_nxt;
            crc_q        <= crc_nxt;
            len_q        <= len_nxt;
            frame_err_q  <= frame_err_nxt;
            pend_valid_q <= pend_valid_nxt;
            pend_q       <= pend_nxt;
        end
    end

    // Output stage: publish the report and bump the matching counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_valid    <= 1'b0;
            status_crc_ok   <= 1'b0;
            status_len_err  <= 1'b0;
            status_ctrl_err <= 1'b0;
            status_len      <= '0;
            good_frames     <= '0;
            bad_frames      <= '0;
        end else begin
            status_valid <= pend_valid_q;
            if (pend_valid_q) begin
                status_crc_ok   <= pend_q.crc_ok;
                status_len_err  <= pend_q.len_err;
                status_ctrl_err <= pend_q.ctrl_err;
                status_len      <= pend_q.len;
                if (pend_q.crc_ok && !pend_q.len_err && !pend_q.ctrl_err) begin
                    good_frames <= good_frames + CNT_W'(1);
                end else begin
                    bad_frames <= bad_frames + CNT_W'(1);
                end
            end
        end
    end

endmodule
